// File: rtl/uart_mem_bridge.sv
// UART-driven debug initiator for the 16-bit MCU memory bus.
// Decodes 'W'/'R' command frames from uart_rx, runs one bus cycle per frame and replies through uart_tx.
module uart_mem_bridge #(
    parameter int unsigned RX_TIMEOUT  = 72000,
    parameter int unsigned BUS_TIMEOUT = 268435455,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_72m,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        rx_error,
    output logic [7:0]  tx_data,
    output logic        tx_ready,
    input  logic        tx_busy,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    output logic        bus_en,
    output logic        bus_we,
    input  logic        bus_ready,
    output logic        busy,
    output logic        err_flag
);

    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] RSP_ACK     = 8'h4B;
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;

    localparam int unsigned    RXW      = $clog2(RX_TIMEOUT + 1);
    localparam logic [RXW-1:0] RX_LAST  = RXW'(RX_TIMEOUT - 1);
    localparam logic [27:0]    BUS_LAST = 28'(BUS_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        GET_AH,
        GET_AL,
        GET_DH,
        GET_DL,
        BUS_REQ,
        BUS_WAIT,
        TX_LOAD,
        TX_GUARD,
        TX_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic                   is_write_q, is_write_d;
    logic [15:0]            bus_addr_q, bus_addr_d;
    logic [15:0]            bus_wdata_q, bus_wdata_d;
    logic                   bus_en_q, bus_en_d;
    logic                   bus_we_q, bus_we_d;
    logic [15:0]            resp_q, resp_d;
    logic [1:0]             resp_cnt_q, resp_cnt_d;
    logic                   resp_ok_q, resp_ok_d;
    logic                   err_q, err_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_ready_q, tx_ready_d;
    logic [RXW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [27:0]            bus_cnt_q, bus_cnt_d;
    logic                   guard_q, guard_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ready_s;

    assign ready_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_72m or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            is_write_q  <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_en_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            resp_q      <= '0;
            resp_cnt_q  <= '0;
            resp_ok_q   <= 1'b0;
            err_q       <= 1'b0;
            tx_data_q   <= '0;
            tx_ready_q  <= 1'b0;
            rx_cnt_q    <= '0;
            bus_cnt_q   <= '0;
            guard_q     <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_en_q    <= bus_en_d;
            bus_we_q    <= bus_we_d;
            resp_q      <= resp_d;
            resp_cnt_q  <= resp_cnt_d;
            resp_ok_q   <= resp_ok_d;
            err_q       <= err_d;
            tx_data_q   <= tx_data_d;
            tx_ready_q  <= tx_ready_d;
            rx_cnt_q    <= rx_cnt_d;
            bus_cnt_q   <= bus_cnt_d;
            guard_q     <= guard_d;
            sync_q      <= sync_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_en_d    = bus_en_q;
        bus_we_d    = bus_we_q;
        resp_d      = resp_q;
        resp_cnt_d  = resp_cnt_q;
        resp_ok_d   = resp_ok_q;
        err_d       = err_q;
        tx_data_d   = tx_data_q;
        tx_ready_d  = 1'b0;
        rx_cnt_d    = rx_cnt_q;
        bus_cnt_d   = bus_cnt_q;
        guard_d     = guard_q;
        sync_d      = (sync_q << 1) | SYNC_STAGES'(bus_ready);

        case (state_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (rx_error) begin
                    err_d = 1'b1;
                end else if (rx_ready) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        is_write_d = (rx_data == CMD_WRITE);
                        state_d    = GET_AH;
                    end else begin
                        resp_d     = {RSP_UNKNOWN, 8'h00};
                        resp_cnt_d = 2'd1;
                        resp_ok_d  = 1'b0;
                        err_d      = 1'b1;
                        state_d    = TX_LOAD;
                    end
                end
            end

            GET_AH, GET_AL, GET_DH, GET_DL: begin
                if (rx_error) begin
                    err_d    = 1'b1;
                    rx_cnt_d = '0;
                    state_d  = IDLE;
                end else if (rx_ready) begin
                    rx_cnt_d = '0;
                    if (state_q == GET_AH) begin
                        bus_addr_d[15:8] = rx_data;
                        state_d          = GET_AL;
                    end else if (state_q == GET_AL) begin
                        bus_addr_d[7:0] = rx_data;
                        state_d         = is_write_q ? GET_DH : BUS_REQ;
                    end else if (state_q == GET_DH) begin
                        bus_wdata_d[15:8] = rx_data;
                        state_d           = GET_DL;
                    end else begin
                        bus_wdata_d[7:0] = rx_data;
                        state_d          = BUS_REQ;
                    end
                end else if (rx_cnt_q == RX_LAST) begin
                    // Inter-byte gap too long: drop the frame silently.
                    err_d    = 1'b1;
                    rx_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end

            BUS_REQ: begin
                if (rx_error) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    bus_en_d  = 1'b1;
                    bus_we_d  = is_write_q;
                    bus_cnt_d = '0;
                    state_d   = BUS_WAIT;
                end
            end

            BUS_WAIT: begin
                if (rx_error) begin
                    bus_en_d = 1'b0;
                    bus_we_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else if (ready_s) begin
                    bus_en_d  = 1'b0;
                    bus_we_d  = 1'b0;
                    resp_ok_d = 1'b1;
                    state_d   = TX_LOAD;
                    if (is_write_q) begin
                        resp_d     = {RSP_ACK, 8'h00};
                        resp_cnt_d = 2'd1;
                    end else begin
                        resp_d     = bus_rdata;
                        resp_cnt_d = 2'd2;
                    end
                end else if (bus_cnt_q == BUS_LAST) begin
                    bus_en_d   = 1'b0;
                    bus_we_d   = 1'b0;
                    err_d      = 1'b1;
                    resp_d     = {RSP_TIMEOUT, 8'h00};
                    resp_cnt_d = 2'd1;
                    resp_ok_d  = 1'b0;
                    state_d    = TX_LOAD;
                end else begin
                    bus_cnt_d = bus_cnt_q + 1'b1;
                end
            end

            TX_LOAD: begin
                if (!tx_busy) begin
                    tx_data_d  = resp_q[15:8];
                    tx_ready_d = 1'b1;
                    resp_d     = {resp_q[7:0], 8'h00};
                    resp_cnt_d = resp_cnt_q - 1'b1;
                    guard_d    = 1'b0;
                    state_d    = TX_GUARD;
                    if (resp_cnt_q == 2'd1 && resp_ok_q) begin
                        err_d = 1'b0;
                    end
                end
            end

            TX_GUARD: begin
                if (guard_q) begin
                    state_d = TX_WAIT;
                end else begin
                    guard_d = 1'b1;
                end
            end

            TX_WAIT: begin
                if (!tx_busy) begin
                    state_d = (resp_cnt_q != 2'd0) ? TX_LOAD : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_data   = tx_data_q;
    assign tx_ready  = tx_ready_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_en    = bus_en_q;
    assign bus_we    = bus_we_q;
    assign busy      = (state_q != IDLE);
    assign err_flag  = err_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Randomized bench for uart_mem_bridge: UART and bus responder models plus a frame-level reference model.
module tb_uart_mem_bridge;

    typedef struct packed {
        logic [15:0] a;
        logic        we;
        logic [15:0] d;
    } txn_t;

    logic        clk_72m   = 1'b0;
    logic        reset     = 1'b0;
    logic [7:0]  rx_data   = '0;
    logic        rx_ready  = 1'b0;
    logic        rx_error  = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_busy   = 1'b0;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata = '0;
    logic        bus_en;
    logic        bus_we;
    logic        bus_ready = 1'b0;
    logic        busy;
    logic        err_flag;

    int n_checks = 0;
    int n_errors = 0;

    uart_mem_bridge #(
        .RX_TIMEOUT (100),
        .BUS_TIMEOUT(50),
        .SYNC_STAGES(2)
    ) dut (
        .clk_72m  (clk_72m),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_error (rx_error),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_en   (bus_en),
        .bus_we   (bus_we),
        .bus_ready(bus_ready),
        .busy     (busy),
        .err_flag (err_flag)
    );

    always #5 clk_72m = ~clk_72m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART transmitter model: goes busy one cycle after each strobe for tx_len cycles
    logic [7:0] tx_q[$];
    int         tx_len     = 4;
    logic       force_busy = 1'b0;
    int         n_strobes  = 0;
    int         busy_left  = 0;
    bit         pend       = 1'b0;
    logic       rdy_prev   = 1'b0;

    always @(negedge clk_72m) begin
        if (tx_ready) begin
            check("tx_strobe_width", rdy_prev, 0);
            check("tx_strobe_while_busy", tx_busy, 0);
            tx_q.push_back(tx_data);
            n_strobes++;
            pend = 1'b1;
        end else if (pend) begin
            pend      = 1'b0;
            busy_left = tx_len;
        end
        rdy_prev = tx_ready;
        tx_busy  = force_busy || (busy_left > 0);
        if (busy_left > 0) busy_left--;
    end

    // Bus responder with its own 64K x 16 memory
    bit [15:0] bus_mem [0:65535];
    txn_t      bus_q[$];
    int        en_len_q[$];
    int        ack_delay = 3;
    bit        ack_mode  = 1'b1;
    logic      late_req  = 1'b0;
    logic      en_prev   = 1'b0;
    int        en_cnt    = 0;
    bit        acked     = 1'b0;
    txn_t      cap;

    always @(negedge clk_72m) begin
        if (bus_en) begin
            if (!en_prev) begin
                cap.a  = bus_addr;
                cap.we = bus_we;
                cap.d  = bus_wdata;
                bus_q.push_back(cap);
                en_cnt = 0;
            end else begin
                check("bus_hold_addr", bus_addr, cap.a);
                check("bus_hold_we_wdata", {bus_we, bus_wdata}, {cap.we, cap.d});
            end
            en_cnt++;
            if (ack_mode && !acked && en_cnt == ack_delay) begin
                acked = 1'b1;
                if (bus_we) bus_mem[bus_addr] = bus_wdata;
                else bus_rdata = bus_mem[bus_addr];
            end
        end else begin
            if (en_prev) en_len_q.push_back(en_cnt);
            acked = 1'b0;
        end
        en_prev   = bus_en;
        bus_ready = (acked && bus_en) || late_req;
    end

    // Reference model state
    bit [15:0]  ref_mem [0:65535];
    logic [7:0] exp_tx[$];
    txn_t       exp_bus[$];
    logic       model_err = 1'b0;
    logic [15:0] pool[8];

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk_72m);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk_72m);
        rx_ready = 1'b0;
        repeat (gap) @(negedge clk_72m);
    endtask

    // kind: 0 write, 1 read, 2 unknown command (d[7:0] is the command byte)
    task automatic send_frame(input int kind, input logic [15:0] a, input logic [15:0] d, input int gmax);
        logic [7:0] b[$];
        txn_t       t;
        if (kind == 0) begin
            b.push_back(8'h57); b.push_back(a[15:8]); b.push_back(a[7:0]);
            b.push_back(d[15:8]); b.push_back(d[7:0]);
            t.a = a; t.we = 1'b1; t.d = d;
            exp_bus.push_back(t);
            exp_tx.push_back(8'h4B);
            ref_mem[a] = d;
            model_err  = 1'b0;
        end else if (kind == 1) begin
            b.push_back(8'h52); b.push_back(a[15:8]); b.push_back(a[7:0]);
            t.a = a; t.we = 1'b0; t.d = '0;
            exp_bus.push_back(t);
            exp_tx.push_back(ref_mem[a][15:8]);
            exp_tx.push_back(ref_mem[a][7:0]);
            model_err = 1'b0;
        end else begin
            b.push_back(d[7:0]);
            exp_tx.push_back(8'h3F);
            model_err = 1'b1;
        end
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], (i == b.size() - 1) ? 0 : int'($urandom_range(gmax, 0)));
        end
        if (kind != 2) begin
            check("lat_bus_idle", bus_en, 0);
            @(negedge clk_72m);
            check("lat_bus_en", bus_en, 1);
            check("lat_bus_we", bus_we, (kind == 0));
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk_72m);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic clear_all();
        exp_tx.delete();
        exp_bus.delete();
        tx_q.delete();
        bus_q.delete();
    endtask

    task automatic finish_frame(input string tag);
        wait_idle(2000);
        check({tag, ".rsp_cnt"}, tx_q.size(), exp_tx.size());
        foreach (exp_tx[i]) begin
            if (i < tx_q.size()) check({tag, ".rsp_byte"}, tx_q[i], exp_tx[i]);
        end
        check({tag, ".bus_cnt"}, bus_q.size(), exp_bus.size());
        foreach (exp_bus[i]) begin
            if (i < bus_q.size()) begin
                check({tag, ".bus_addr"}, bus_q[i].a, exp_bus[i].a);
                check({tag, ".bus_we"}, bus_q[i].we, exp_bus[i].we);
                if (exp_bus[i].we) check({tag, ".bus_wdata"}, bus_q[i].d, exp_bus[i].d);
            end
        end
        check({tag, ".err_flag"}, err_flag, model_err);
        clear_all();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: still running at %0t, expected $finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int kind;
        logic [7:0] c;

        foreach (pool[i]) pool[i] = 16'($urandom);
        pool[0] = 16'h1234;

        repeat (3) @(negedge clk_72m);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_bus_en", bus_en, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_busy", busy, 0);
        check("rst_err_flag", err_flag, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk_72m);

        // Write then read back through the 3-cycle-ack responder
        send_frame(0, 16'h1234, 16'hBEEF, 0);
        finish_frame("wr");
        send_frame(1, 16'h1234, 16'h0000, 0);
        finish_frame("rd");

        // Unknown command, then a read clears the error
        send_frame(2, 16'h0000, 16'h0041, 0);
        check("unk_no_bus", bus_q.size(), 0);
        finish_frame("unk");
        send_frame(1, 16'h1234, 16'h0000, 0);
        finish_frame("unk_clear");

        // RX timeout mid-frame
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        check("rxto_busy_mid", busy, 1);
        repeat (150) @(negedge clk_72m);
        check("rxto_busy", busy, 0);
        check("rxto_no_bus", bus_q.size(), 0);
        check("rxto_no_reply", tx_q.size(), 0);
        check("rxto_err", err_flag, 1);
        model_err = 1'b1;
        send_frame(1, 16'h0005, 16'h0000, 0);
        finish_frame("rxto_recover");

        // rx_error during a frame aborts it
        send_byte(8'h52, 0);
        send_byte(8'h00, 0);
        rx_error = 1'b1;
        @(negedge clk_72m);
        rx_error = 1'b0;
        repeat (5) @(negedge clk_72m);
        check("rxerr_busy", busy, 0);
        check("rxerr_no_bus", bus_q.size(), 0);
        check("rxerr_no_reply", tx_q.size(), 0);
        check("rxerr_err", err_flag, 1);
        model_err = 1'b1;

        // Bus timeout with a responder that never acks
        ack_mode = 1'b0;
        en_len_q.delete();
        send_frame(1, 16'h0001, 16'h0000, 0);
        exp_tx.delete();
        exp_tx.push_back(8'h54);
        model_err = 1'b1;
        finish_frame("busto");
        check("busto_en_pulses", en_len_q.size(), 1);
        if (en_len_q.size() > 0) check("busto_en_len", en_len_q[0], 50);
        late_req = 1'b1;
        repeat (4) @(negedge clk_72m);
        late_req = 1'b0;
        repeat (10) @(negedge clk_72m);
        check("late_busy", busy, 0);
        check("late_no_reply", tx_q.size(), 0);
        check("late_no_bus", bus_en, 0);
        check("late_err", err_flag, 1);
        ack_mode = 1'b1;

        // TX backpressure during a read reply
        force_busy = 1'b1;
        s0 = n_strobes;
        send_frame(1, 16'h1234, 16'h0000, 0);
        repeat (500) @(negedge clk_72m);
        check("bp_no_strobe", n_strobes - s0, 0);
        force_busy = 1'b0;
        finish_frame("bp");
        check("bp_strobes", n_strobes - s0, 2);

        // Asynchronous reset while waiting on the bus
        ack_mode = 1'b0;
        send_frame(1, 16'h0000, 16'h0000, 0);
        repeat (5) @(negedge clk_72m);
        #2 reset = 1'b0;
        #1;
        check("arst_bus_en", bus_en, 0);
        check("arst_busy", busy, 0);
        check("arst_tx_ready", tx_ready, 0);
        check("arst_err", err_flag, 0);
        @(negedge clk_72m);
        reset = 1'b1;
        repeat (20) @(negedge clk_72m);
        check("arst_no_reply", tx_q.size(), 0);
        clear_all();
        en_len_q.delete();
        model_err = 1'b0;
        ack_mode  = 1'b1;
        send_frame(1, 16'h0000, 16'h0000, 0);
        finish_frame("arst_recover");

        // Randomized frames against the reference model
        for (int n = 0; n < 40; n++) begin
            ack_delay = $urandom_range(6, 1);
            tx_len    = $urandom_range(12, 0);
            kind      = $urandom_range(9, 0);
            if (kind < 4) begin
                send_frame(0, pool[$urandom_range(7, 0)], 16'($urandom), 3);
            end else if (kind < 8) begin
                send_frame(1, pool[$urandom_range(7, 0)], 16'h0000, 3);
            end else begin
                do c = 8'($urandom); while (c == 8'h57 || c == 8'h52);
                send_frame(2, 16'h0000, {8'h00, c}, 0);
            end
            finish_frame("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
